// File: rtl/rx.sv
`timescale 1ns/1ps
// Serial receive stage of the mini SPART: recovers 8N1 frames from RxD using the 16x
// oversample enable tick and presents each byte with ready, framing and overrun flags.
module rx #(
    parameter int unsigned OVS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Enable,
    input  logic       RxD,
    input  logic       RxD_ack,
    output logic [7:0] RxD_data,
    output logic       RDA,
    output logic       FE,
    output logic       OE
);

    localparam logic [3:0] TickLast = 4'(OVS - 1);
    localparam logic [3:0] TickHalf = 4'(OVS / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] sync_q;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       rda_q, rda_d;
    logic       fe_q, fe_d;
    logic       oe_q, oe_d;
    logic       rxs;
    logic       frame_ok;
    logic       frame_err;

    assign rxs = sync_q[1];

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        if (Enable) begin
            unique case (state_q)
                StIdle: begin
                    // The detection tick itself counts as the first start-bit tick.
                    if (!rxs) begin
                        state_d = StStart;
                        tick_d  = 4'd1;
                        bit_d   = 3'd0;
                    end
                end
                StStart: begin
                    if (tick_q == TickHalf) begin
                        tick_d  = 4'd0;
                        bit_d   = 3'd0;
                        state_d = rxs ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                StData: begin
                    if (tick_q == TickLast) begin
                        tick_d  = 4'd0;
                        shift_d = {rxs, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = StStop;
                            bit_d   = 3'd0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                StStop: begin
                    if (tick_q == TickLast) begin
                        tick_d = 4'd0;
                        if (rxs) begin
                            state_d  = StIdle;
                            frame_ok = 1'b1;
                        end else begin
                            state_d   = StWaitIdle;
                            frame_err = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                StWaitIdle: begin
                    // Hold off until the line returns high so a break cannot retrigger.
                    if (rxs) begin
                        state_d = StIdle;
                        tick_d  = 4'd0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    tick_d  = 4'd0;
                    bit_d   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        data_d = data_q;
        rda_d  = rda_q;
        fe_d   = fe_q;
        oe_d   = oe_q;
        if (RxD_ack) begin
            rda_d = 1'b0;
            fe_d  = 1'b0;
            oe_d  = 1'b0;
        end
        // A same-cycle ack frees the holding register, so the new byte is not an overrun.
        if (frame_ok) begin
            if (!rda_q || RxD_ack) begin
                data_d = shift_q;
                rda_d  = 1'b1;
            end else begin
                oe_d = 1'b1;
            end
        end
        if (frame_err) begin
            fe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            rda_q   <= 1'b0;
            fe_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], RxD};
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rda_q   <= rda_d;
            fe_q    <= fe_d;
            oe_q    <= oe_d;
        end
    end

    assign RxD_data = data_q;
    assign RDA      = rda_q;
    assign FE       = fe_q;
    assign OE       = oe_q;

endmodule
